// File: rtl/axi_rd_router_if.sv
// AXI4 read-channel bundle (AR + R) used for the upstream port and for
// each downstream slave of axi_rd_router.
//   master: drives AR payload/arvalid and rready (the requester side)
//   slave : drives arready and the R payload/rvalid/rlast (the responder side)
interface axi_rd_router_if;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rvalid;
    logic        rlast;
    logic        rready;

    modport master (
        output araddr, arid, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rid, rvalid, rlast
    );

    modport slave (
        input  araddr, arid, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rid, rvalid, rlast
    );
endinterface

// File: rtl/axi_rd_router.sv
// axi_rd_router: routes single-outstanding AXI4 reads from the LSU to main
// memory or the CLINT, holding the R-channel route until the rlast beat.
//
// Optional feature macro: AXI_RD_ROUTER_DECERR_EN
//   defined   -> unmapped addresses are answered locally with DECERR bursts
//   undefined -> unmapped addresses are forwarded to memory
//
// Handshake semantics: every channel transfers a beat on a rising clock edge
// where valid and ready are both 1; valid never waits on ready. The router
// forwards valid/ready combinationally and adds no latency on either path.
module axi_rd_router #(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000,
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [31:0] MEM_MASK   = 32'hF800_0000
) (
    input  logic                    clock,
    input  logic                    reset_n,
    axi_rd_router_if.slave          up,
    axi_rd_router_if.master         mem,
    axi_rd_router_if.master         clint,
    output logic [1:0]              dbg_state,
    output logic                    dbg_unmapped
);

`ifdef AXI_RD_ROUTER_DECERR_EN
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_FWD_MEM   = 2'd1,
        S_FWD_CLINT = 2'd2,
        S_ERR       = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_FWD_MEM   = 2'd1,
        S_FWD_CLINT = 2'd2
    } state_t;
`endif

    state_t state_q, state_d;
    state_t dec_sel;
    logic   clint_hit, mem_hit;
    logic   ar_rdy, ar_hs;

`ifdef AXI_RD_ROUTER_DECERR_EN
    logic [7:0] beat_cnt;
    logic [3:0] cap_arid;
`endif

    assign clint_hit    = (up.araddr & CLINT_MASK) == CLINT_BASE;
    assign mem_hit      = (up.araddr & MEM_MASK) == MEM_BASE;
    assign dbg_unmapped = ~clint_hit & ~mem_hit;
    assign dbg_state    = state_q;

    // Address decode: CLINT wins when both windows match.
    always_comb begin
        dec_sel = S_FWD_MEM;
        if (clint_hit) begin
            dec_sel = S_FWD_CLINT;
        end else if (!mem_hit) begin
`ifdef AXI_RD_ROUTER_DECERR_EN
            dec_sel = S_ERR;
`else
            dec_sel = S_FWD_MEM;
`endif
        end
    end

    // AR payload is broadcast; only arvalid decides which slave takes it.
    assign mem.araddr    = up.araddr;
    assign mem.arid      = up.arid;
    assign mem.arlen     = up.arlen;
    assign mem.arsize    = up.arsize;
    assign mem.arburst   = up.arburst;
    assign clint.araddr  = up.araddr;
    assign clint.arid    = up.arid;
    assign clint.arlen   = up.arlen;
    assign clint.arsize  = up.arsize;
    assign clint.arburst = up.arburst;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic and all handshake/R-channel steering.
    always_comb begin
        state_d       = state_q;
        ar_rdy        = 1'b0;
        ar_hs         = 1'b0;
        up.arready    = 1'b0;
        up.rvalid     = 1'b0;
        up.rlast      = 1'b0;
        up.rdata      = '0;
        up.rresp      = 2'b00;
        up.rid        = '0;
        mem.arvalid   = 1'b0;
        mem.rready    = 1'b0;
        clint.arvalid = 1'b0;
        clint.rready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                case (dec_sel)
                    S_FWD_CLINT: begin
                        clint.arvalid = up.arvalid;
                        ar_rdy        = clint.arready;
                    end
                    S_FWD_MEM: begin
                        mem.arvalid = up.arvalid;
                        ar_rdy      = mem.arready;
                    end
                    default: begin
                        // Unmapped: the router itself accepts the request.
                        ar_rdy = 1'b1;
                    end
                endcase
                up.arready = ar_rdy;
                ar_hs      = up.arvalid & ar_rdy;
                if (ar_hs) state_d = dec_sel;
            end
            S_FWD_MEM: begin
                up.rvalid  = mem.rvalid;
                up.rlast   = mem.rlast;
                up.rdata   = mem.rdata;
                up.rresp   = mem.rresp;
                up.rid     = mem.rid;
                mem.rready = up.rready;
                if (mem.rvalid && up.rready && mem.rlast) state_d = S_IDLE;
            end
            S_FWD_CLINT: begin
                up.rvalid    = clint.rvalid;
                up.rlast     = clint.rlast;
                up.rdata     = clint.rdata;
                up.rresp     = clint.rresp;
                up.rid       = clint.rid;
                clint.rready = up.rready;
                if (clint.rvalid && up.rready && clint.rlast) state_d = S_IDLE;
            end
`ifdef AXI_RD_ROUTER_DECERR_EN
            S_ERR: begin
                up.rvalid = 1'b1;
                up.rresp  = 2'b11;
                up.rid    = cap_arid;
                up.rlast  = (beat_cnt == 8'd0);
                if (up.rready && beat_cnt == 8'd0) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

`ifdef AXI_RD_ROUTER_DECERR_EN
    // DECERR burst bookkeeping: remaining-beat counter and the id to echo.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt <= 8'd0;
            cap_arid <= 4'd0;
        end else if (state_q == S_IDLE && ar_hs) begin
            beat_cnt <= up.arlen;
            cap_arid <= up.arid;
        end else if (state_q == S_ERR && up.rready && beat_cnt != 8'd0) begin
            beat_cnt <= beat_cnt - 8'd1;
        end
    end
`endif

endmodule
